mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port req0, input, 1 bit: instruction-fetch request; held high until ack0.
REQ-004 The block SHALL have the port addr0, input, 32 bits: fetch address; stable while req0 is high.
REQ-005 The block SHALL have the port ack0, output, 1 bit: one-cycle completion pulse; rdata valid in the same cycle.
REQ-006 The block SHALL have the port req1, input, 1 bit: data request; held high until ack1.
REQ-007 The block SHALL have the ports addr1 and wdata1, input, 32 bits each; both stable while req1 is high.
REQ-008 The block SHALL have the port we1, input, 1 bit: write enable, where 1 means store and 0 means load.
REQ-009 The block SHALL have the port ack1, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have the port rdata, output, 32 bits: registered read data returned to the acked port.
REQ-011 The block SHALL have the ports mem_req and mem_we, output, 1 bit each: shared-memory request and write strobe.
REQ-012 The block SHALL have the ports mem_addr and mem_wdata, output, 32 bits each: shared-memory address and write data.
REQ-013 The block SHALL have the ports mem_rdata (input, 32 bits) and mem_ready (input, 1 bit): memory read data and completion indication.
REQ-014 The block SHALL have the port grant, output, 1 bit: current owner, 0 = fetch and 1 = data; it drives downstream 2:1 select muxes.

Function
REQ-015 The controller SHALL be an FSM with three states: IDLE, BUSY and DONE.
REQ-016 In IDLE with any request pending, the block SHALL latch grant and enter BUSY on the next edge; with no request, it SHALL stay in IDLE.
REQ-017 In BUSY, mem_req SHALL be 1, mem_addr SHALL be the granted port's address, and mem_we SHALL equal we1 when grant = 1 and 0 when grant = 0.
REQ-018 mem_wdata SHALL equal wdata1 when grant = 1 and 32'h0 otherwise.
REQ-019 Outside BUSY, mem_req, mem_we, mem_addr and mem_wdata SHALL all be 0.
REQ-020 In BUSY with mem_ready = 1, the block SHALL capture mem_rdata into rdata and enter DONE; with mem_ready = 0, it SHALL remain in BUSY indefinitely.
REQ-021 In DONE, ack[grant] SHALL be 1 for exactly one cycle, the other ack SHALL be 0, and the next state SHALL be IDLE unconditionally.
REQ-022 Minimum latency SHALL be 3 cycles from req sampled in IDLE to ack, with mem_ready in the first BUSY cycle.
REQ-023 rdata SHALL hold its value until the next capture; for writes it SHALL capture mem_rdata without qualification.
REQ-024 Arbitration SHALL use a last_grant register: a single request wins, and on simultaneous requests the port with last_grant != port wins.
REQ-025 last_grant SHALL update when entering DONE.
REQ-026 grant SHALL hold constant from IDLE exit through DONE and SHALL NOT change while mem_req is high.
REQ-027 A request deasserted before its ack is a protocol violation; behaviour is undefined and need not be detected.
REQ-028 req must be low in the cycle after ack; a req still high in IDLE SHALL be treated as a new request.

Reset
REQ-029 When rst = 1 at an edge, state SHALL become IDLE, grant 0, last_grant 1, rdata 32'h0, and ack0, ack1 and mem_req 0.
REQ-030 Reset during BUSY or DONE SHALL abort the transaction: no ack is issued, and mem_req is low in the cycle after the edge.

Configuration
REQ-031 With the macro MEM_ARB_DATA_PRIORITY_EN defined, simultaneous requests SHALL always grant port 1, and last_grant SHALL be ignored.
REQ-032 With the macro MEM_ARB_DATA_PRIORITY_EN undefined, arbitration SHALL be round-robin per REQ-024; the port list SHALL be identical in both builds.

Verification
REQ-033 The bench SHALL cover: after reset, req0=1, addr0=32'h00400000, mem_ready=1 with mem_rdata=32'h8C080004 -> mem_req for 1 cycle, ack0 at cycle 3, rdata=32'h8C080004.
REQ-034 The bench SHALL cover: req1=1, we1=1, addr1=32'h10010000, wdata1=32'hDEADBEEF -> mem_we=1, mem_addr and mem_wdata match, ack1 pulses once, ack0 stays 0.
REQ-035 The bench SHALL cover: req0 and req1 both high from reset, round-robin build -> order port0, port1, port0, port1; priority build -> port1 repeatedly while req1 stays high.
REQ-036 The bench SHALL cover: mem_ready held 0 for 5 BUSY cycles -> mem_req high for 6 cycles, grant constant, and a single ack.
REQ-037 The bench SHALL cover: rst asserted in the second BUSY cycle -> mem_req 0 and ack0=ack1=0 next cycle, grant 0, and a following req0 served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Two-port (instruction fetch / data) arbiter in front of one shared memory
// port. A transaction walks IDLE -> BUSY -> DONE; the memory is driven only
// in BUSY, and the completion pulse plus registered read data appear in DONE.
//
// Build option: define MEM_ARB_DATA_PRIORITY_EN to make the data port win
// every simultaneous request. Without it, simultaneous requests alternate
// round-robin using the last granted port. The port list is identical in
// both builds.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    // instruction-fetch port
    input  logic        req0,
    input  logic [31:0] addr0,
    output logic        ack0,
    // data port
    input  logic        req1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic        we1,
    output logic        ack1,
    // read data returned to whichever port is acked
    output logic [31:0] rdata,
    // shared memory side
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    // current owner: 0 = fetch, 1 = data
    output logic        grant
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_grant;
    logic        r_last_grant;
    logic [31:0] r_rdata;
    logic        w_any_req;
    logic        w_arb_grant;

    assign w_any_req = req0 | req1;

    // Arbitration decision; only consumed when leaving IDLE
    always_comb begin
        w_arb_grant = req1;
`ifdef MEM_ARB_DATA_PRIORITY_EN
        // Data port wins whenever it is requesting.
        w_arb_grant = req1;
`else
        // Simultaneous requests go to the port that was not served last.
        if (req0 && req1) begin
            w_arb_grant = ~r_last_grant;
        end
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Grant, last-grant history and read data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_rdata      <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_grant <= w_arb_grant;
            end
            if ((r_state == ST_BUSY) && mem_ready) begin
                r_rdata      <= mem_rdata;
                r_last_grant <= r_grant;
            end
        end
    end

    // Output decode: memory strobes in BUSY, completion pulse in DONE
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        case (r_state)
            ST_BUSY: begin
                mem_req = 1'b1;
                if (r_grant) begin
                    mem_we    = we1;
                    mem_addr  = addr1;
                    mem_wdata = wdata1;
                end else begin
                    mem_addr  = addr0;
                end
            end
            ST_DONE: begin
                ack0 = ~r_grant;
                ack1 = r_grant;
            end
            default: begin
            end
        endcase
    end

    assign grant = r_grant;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter.
// Inputs change 2 time units after the rising edge; outputs are checked at
// that same point, well away from the next active edge.
// Define MEM_ARB_DATA_PRIORITY_EN for both bench and RTL to check the
// data-priority build.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        req0;
    logic [31:0] addr0;
    logic        ack0;
    logic        req1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        we1;
    logic        ack1;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        grant;

    int unsigned n_tests;
    int unsigned n_fail;

    mem_port_arbiter u_dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .addr0     (addr0),
        .ack0      (ack0),
        .req1      (req1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .we1       (we1),
        .ack1      (ack1),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic exp_g;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req0      = 1'b0;
        addr0     = '0;
        req1      = 1'b0;
        addr1     = '0;
        wdata1    = '0;
        we1       = 1'b0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_ack0",    {31'b0, ack0},    32'd0);
        check("rst_ack1",    {31'b0, ack1},    32'd0);
        check("rst_grant",   {31'b0, grant},   32'd0);
        check("rst_rdata",   rdata,            32'h0);
        check("rst_mem_addr", mem_addr,        32'h0);

        // Single fetch read, memory ready immediately
        req0      = 1'b1;
        addr0     = 32'h0040_0000;
        mem_ready = 1'b1;
        mem_rdata = 32'h8C08_0004;
        check("rd_idle_mem_req", {31'b0, mem_req}, 32'd0);
        tick();
        check("rd_busy_mem_req", {31'b0, mem_req}, 32'd1);
        check("rd_busy_addr",    mem_addr,         32'h0040_0000);
        check("rd_busy_we",      {31'b0, mem_we},  32'd0);
        check("rd_busy_wdata",   mem_wdata,        32'h0);
        check("rd_busy_grant",   {31'b0, grant},   32'd0);
        check("rd_busy_ack0",    {31'b0, ack0},    32'd0);
        tick();
        check("rd_done_ack0",    {31'b0, ack0},    32'd1);
        check("rd_done_ack1",    {31'b0, ack1},    32'd0);
        check("rd_done_rdata",   rdata,            32'h8C08_0004);
        check("rd_done_mem_req", {31'b0, mem_req}, 32'd0);
        req0 = 1'b0;
        tick();
        check("rd_idle_ack0",    {31'b0, ack0},    32'd0);
        check("rd_idle_rdata",   rdata,            32'h8C08_0004);
        mem_rdata = 32'h1234_5678;
        tick();
        check("rd_hold_rdata",   rdata,            32'h8C08_0004);
        check("rd_hold_mem_req", {31'b0, mem_req}, 32'd0);

        // Single data write; rdata captures mem_rdata unqualified
        req1   = 1'b1;
        we1    = 1'b1;
        addr1  = 32'h1001_0000;
        wdata1 = 32'hDEAD_BEEF;
        tick();
        check("wr_busy_mem_req", {31'b0, mem_req}, 32'd1);
        check("wr_busy_we",      {31'b0, mem_we},  32'd1);
        check("wr_busy_addr",    mem_addr,         32'h1001_0000);
        check("wr_busy_wdata",   mem_wdata,        32'hDEAD_BEEF);
        check("wr_busy_grant",   {31'b0, grant},   32'd1);
        check("wr_busy_ack1",    {31'b0, ack1},    32'd0);
        tick();
        check("wr_done_ack1",    {31'b0, ack1},    32'd1);
        check("wr_done_ack0",    {31'b0, ack0},    32'd0);
        check("wr_done_rdata",   rdata,            32'h1234_5678);
        check("wr_done_mem_we",  {31'b0, mem_we},  32'd0);
        req1 = 1'b0;
        we1  = 1'b0;
        tick();
        check("wr_idle_ack1",    {31'b0, ack1},    32'd0);

        // Simultaneous requests from reset
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
`ifdef MEM_ARB_DATA_PRIORITY_EN
            exp_g = 1'b1;
`else
            exp_g = (i % 2 == 1) ? 1'b1 : 1'b0;
`endif
            mem_rdata = 32'hA000_0000 + i;
            tick();
            check($sformatf("arb%0d_busy_grant", i), {31'b0, grant},   {31'b0, exp_g});
            check($sformatf("arb%0d_busy_addr", i),  mem_addr,         exp_g ? addr1 : addr0);
            tick();
            check($sformatf("arb%0d_done_grant", i), {31'b0, grant},   {31'b0, exp_g});
            check($sformatf("arb%0d_ack0", i),       {31'b0, ack0},    {31'b0, ~exp_g});
            check($sformatf("arb%0d_ack1", i),       {31'b0, ack1},    {31'b0, exp_g});
            check($sformatf("arb%0d_rdata", i),      rdata,            32'hA000_0000 + i);
            if (exp_g) req1 = 1'b0;
            else       req0 = 1'b0;
            tick();
            req0 = 1'b1;
            req1 = 1'b1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();

        // Memory stall: five BUSY cycles without ready, ready on the sixth
        addr0     = 32'h0040_0010;
        req0      = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 32'h5555_AAAA;
        for (int unsigned i = 0; i < 6; i++) begin
            tick();
            check($sformatf("stall%0d_mem_req", i), {31'b0, mem_req}, 32'd1);
            check($sformatf("stall%0d_grant", i),   {31'b0, grant},   32'd0);
            check($sformatf("stall%0d_ack0", i),    {31'b0, ack0},    32'd0);
            if (i == 5) mem_ready = 1'b1;
        end
        tick();
        check("stall_done_ack0",    {31'b0, ack0},    32'd1);
        check("stall_done_mem_req", {31'b0, mem_req}, 32'd0);
        check("stall_done_rdata",   rdata,            32'h5555_AAAA);
        req0 = 1'b0;
        tick();
        check("stall_after_ack0",   {31'b0, ack0},    32'd0);
        tick();
        check("stall_after2_ack0",  {31'b0, ack0},    32'd0);
        check("stall_after2_req",   {31'b0, mem_req}, 32'd0);

        // Reset in the second BUSY cycle aborts the transaction
        req1      = 1'b1;
        we1       = 1'b0;
        addr1     = 32'h1001_0040;
        mem_ready = 1'b0;
        tick();
        check("abort_busy1_grant", {31'b0, grant},   32'd1);
        tick();
        check("abort_busy2_req",   {31'b0, mem_req}, 32'd1);
        rst  = 1'b1;
        req1 = 1'b0;
        tick();
        rst = 1'b0;
        check("abort_mem_req", {31'b0, mem_req}, 32'd0);
        check("abort_ack0",    {31'b0, ack0},    32'd0);
        check("abort_ack1",    {31'b0, ack1},    32'd0);
        check("abort_grant",   {31'b0, grant},   32'd0);
        check("abort_rdata",   rdata,            32'h0);
        req0      = 1'b1;
        addr0     = 32'h0040_0020;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        check("post_busy_req",  {31'b0, mem_req}, 32'd1);
        check("post_busy_addr", mem_addr,         32'h0040_0020);
        tick();
        check("post_done_ack0", {31'b0, ack0},    32'd1);
        check("post_done_ack1", {31'b0, ack1},    32'd0);
        check("post_rdata",     rdata,            32'hCAFE_F00D);
        req0 = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
